// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter between the D-side write-through, D-cache miss and I-cache miss paths.
// Issues pipelined line reads and steers the returned words back to the owning cache.
module mem_arbiter #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_miss_req,
    input  logic [15:0]      i_miss_addr,
    input  logic             d_miss_req,
    input  logic [15:0]      d_miss_addr,
    input  logic             d_wr_req,
    input  logic [15:0]      d_wr_addr,
    input  logic [15:0]      d_wr_data,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_data_valid,
    output logic             fill_valid,
    output logic             fill_sel,
    output logic [CNT_W-1:0] fill_word,
    output logic [15:0]      fill_data,
    output logic             i_fill_done,
    output logic             d_fill_done,
    output logic             d_wr_done,
    output logic             busy
);

    localparam logic [15:0]      LineMask = 16'(LINE_WORDS * 2 - 1);
    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(LINE_WORDS - 1);

    if ((1 << CNT_W) != LINE_WORDS) begin : gBadCntW
        $error("CNT_W must equal log2(LINE_WORDS)");
    end
    if (MEM_LAT < 1) begin : gBadLat
        $error("MEM_LAT must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StWrite, StFillIssue, StFillDrain, StDone} state_e;

    state_e           state;
    logic             ownerQ;
    logic [CNT_W-1:0] issueCnt;
    logic [CNT_W-1:0] retCnt;
    logic             memEnQ;
    logic             memWrQ;
    logic [15:0]      memAddrQ;
    logic [15:0]      memWdataQ;
    logic             iFillDoneQ;
    logic             dFillDoneQ;
    logic             dWrDoneQ;
    logic             inFill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            ownerQ     <= 1'b0;
            issueCnt   <= '0;
            retCnt     <= '0;
            memEnQ     <= 1'b0;
            memWrQ     <= 1'b0;
            memAddrQ   <= '0;
            memWdataQ  <= '0;
            iFillDoneQ <= 1'b0;
            dFillDoneQ <= 1'b0;
            dWrDoneQ   <= 1'b0;
        end else begin
            iFillDoneQ <= 1'b0;
            dFillDoneQ <= 1'b0;
            dWrDoneQ   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (d_wr_req) begin
                        state     <= StWrite;
                        memEnQ    <= 1'b1;
                        memWrQ    <= 1'b1;
                        memAddrQ  <= d_wr_addr;
                        memWdataQ <= d_wr_data;
                        dWrDoneQ  <= 1'b1;
                    end else if (d_miss_req || i_miss_req) begin
                        state    <= StFillIssue;
                        ownerQ   <= d_miss_req;
                        memEnQ   <= 1'b1;
                        memWrQ   <= 1'b0;
                        memAddrQ <= (d_miss_req ? d_miss_addr : i_miss_addr) & ~LineMask;
                        issueCnt <= '0;
                        retCnt   <= '0;
                    end
                end
                StWrite: begin
                    state     <= StIdle;
                    memEnQ    <= 1'b0;
                    memWrQ    <= 1'b0;
                    memAddrQ  <= '0;
                    memWdataQ <= '0;
                end
                StFillIssue, StFillDrain: begin
                    if (state == StFillIssue) begin
                        if (issueCnt == LastCnt) begin
                            state    <= StFillDrain;
                            memEnQ   <= 1'b0;
                            memAddrQ <= '0;
                        end else begin
                            issueCnt <= issueCnt + 1'b1;
                            memAddrQ <= memAddrQ + 16'd2;
                        end
                    end
                    // Return handling sits last so the final beat wins the state update.
                    if (mem_data_valid) begin
                        retCnt <= retCnt + 1'b1;
                        if (retCnt == LastCnt) begin
                            state      <= StDone;
                            memEnQ     <= 1'b0;
                            memAddrQ   <= '0;
                            dFillDoneQ <= ownerQ;
                            iFillDoneQ <= ~ownerQ;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign inFill = (state == StFillIssue) || (state == StFillDrain);

    always_comb begin
        fill_valid = inFill && mem_data_valid;
        fill_sel   = fill_valid && ownerQ;
        fill_word  = fill_valid ? retCnt : '0;
        fill_data  = fill_valid ? mem_rdata : '0;
    end

    assign mem_en      = memEnQ;
    assign mem_wr      = memWrQ;
    assign mem_addr    = memAddrQ;
    assign mem_wdata   = memWdataQ;
    assign i_fill_done = iFillDoneQ;
    assign d_fill_done = dFillDoneQ;
    assign d_wr_done   = dWrDoneQ;
    assign busy        = (state != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-4 pipelined memory model.
// Read data returned by the model is (address ^ 16'h5A5A).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss_req, d_miss_req, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic        fill_valid, fill_sel;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_fill_done, d_fill_done, d_wr_done, busy;

    int nVec = 0;
    int nBad = 0;

    mem_arbiter #(.LINE_WORDS(8), .MEM_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_valid(fill_valid), .fill_sel(fill_sel), .fill_word(fill_word),
        .fill_data(fill_data), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_done(d_wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: read issued in cycle c returns in cycle c+4+extra[beat], in order.
    typedef struct { int due; logic [15:0] data; } rd_t;
    rd_t      rdQ[$];
    int       cyc = 0;
    logic [2:0] idx = '0;
    int       extra [8];
    bit       inject = 1'b0;

    initial begin
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
        for (int i = 0; i < 8; i++) extra[i] = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            rdQ.delete();
            idx = '0;
        end else if (mem_en && !mem_wr) begin
            rdQ.push_back('{due: cyc + 4 + extra[idx], data: mem_addr ^ 16'h5A5A});
            idx = idx + 3'd1;
        end
        cyc = cyc + 1;
        #1;
        if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = rdQ[0].data;
            void'(rdQ.pop_front());
        end else if (inject) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'hDEAD;
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = '0;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        repeat (3) step();
        nVec++;
        if ({busy, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_sel, fill_word,
             fill_data, i_fill_done, d_fill_done, d_wr_done} !== '0) begin
            nBad++; $display("FAIL reset_outputs: some output nonzero, busy=%b mem_en=%b", busy, mem_en);
        end
        rst = 1'b0;
        inject = 1'b1;
        repeat (2) step();
        nVec++;
        if (fill_valid !== 1'b0) begin nBad++; $display("FAIL idle_valid_ignored: fill_valid=%b want 0", fill_valid); end
        nVec++;
        if (busy !== 1'b0) begin nBad++; $display("FAIL idle_busy: busy=%b want 0", busy); end
        inject = 1'b0;
        step();
    endtask

    task automatic test_i_miss;
        logic [15:0] a;
        i_miss_addr = 16'h1236;
        i_miss_req  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            nVec++;
            if (mem_en !== (k >= 1 && k <= 8)) begin nBad++; $display("FAIL imiss_en k=%0d: got %b", k, mem_en); end
            if (k <= 8) begin
                a = 16'h1230 + 16'(2 * (k - 1));
                nVec++;
                if (mem_addr !== a || mem_wr !== 1'b0) begin
                    nBad++; $display("FAIL imiss_addr k=%0d: got %h wr=%b want %h", k, mem_addr, mem_wr, a);
                end
            end
            nVec++;
            if (fill_valid !== (k >= 5 && k <= 12)) begin nBad++; $display("FAIL imiss_valid k=%0d: got %b", k, fill_valid); end
            if (k >= 5 && k <= 12) begin
                a = 16'h1230 + 16'(2 * (k - 5));
                nVec++;
                if (fill_sel !== 1'b0 || fill_word !== 3'(k - 5) || fill_data !== (a ^ 16'h5A5A)) begin
                    nBad++; $display("FAIL imiss_beat k=%0d: sel=%b word=%0d data=%h want word=%0d data=%h",
                                     k, fill_sel, fill_word, fill_data, k - 5, a ^ 16'h5A5A);
                end
            end
            nVec++;
            if (i_fill_done !== (k == 13)) begin nBad++; $display("FAIL imiss_done k=%0d: got %b", k, i_fill_done); end
            if (k == 13) i_miss_req = 1'b0;
            if (k == 14) begin
                nVec++;
                if (busy !== 1'b0) begin nBad++; $display("FAIL imiss_idle: busy=%b want 0", busy); end
            end
        end
    endtask

    task automatic test_write;
        d_wr_addr = 16'h00A4;
        d_wr_data = 16'hBEEF;
        d_wr_req  = 1'b1;
        step();
        nVec++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, d_wr_done} !== {1'b1, 1'b1, 16'h00A4, 16'hBEEF, 1'b1}) begin
            nBad++; $display("FAIL write_cycle: en=%b wr=%b addr=%h wdata=%h done=%b want 1 1 00a4 beef 1",
                             mem_en, mem_wr, mem_addr, mem_wdata, d_wr_done);
        end
        d_wr_req = 1'b0;
        step();
        nVec++;
        if ({busy, mem_en, d_wr_done} !== 3'b000) begin
            nBad++; $display("FAIL write_idle: busy=%b en=%b done=%b want 000", busy, mem_en, d_wr_done);
        end
    endtask

    task automatic test_contention;
        int nWr = 0, nD = 0, nI = 0, wrK = -1, dK = -1, iK = -1, dBeats = 0, iBeats = 0;
        logic [15:0] a;
        logic expEn;
        d_wr_addr = 16'h0010; d_wr_data = 16'h1111;
        d_miss_addr = 16'h2004; i_miss_addr = 16'h3008;
        d_wr_req = 1'b1; d_miss_req = 1'b1; i_miss_req = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            expEn = (k == 1) || (k >= 3 && k <= 10) || (k >= 17 && k <= 24);
            nVec++;
            if (mem_en !== expEn) begin nBad++; $display("FAIL cont_en k=%0d: got %b want %b", k, mem_en, expEn); end
            if (d_wr_done)   begin nWr++; wrK = k; d_wr_req = 1'b0; end
            if (d_fill_done) begin nD++;  dK = k;  d_miss_req = 1'b0; end
            if (i_fill_done) begin nI++;  iK = k;  i_miss_req = 1'b0; end
            if (fill_valid) begin
                a = fill_sel ? 16'h2000 + 16'(2 * dBeats) : 16'h3000 + 16'(2 * iBeats);
                nVec++;
                if (fill_word !== 3'(fill_sel ? dBeats : iBeats) || fill_data !== (a ^ 16'h5A5A)) begin
                    nBad++; $display("FAIL cont_beat k=%0d: sel=%b word=%0d data=%h want data=%h",
                                     k, fill_sel, fill_word, fill_data, a ^ 16'h5A5A);
                end
                if (fill_sel) dBeats++; else iBeats++;
            end
        end
        nVec++;
        if (nWr != 1 || nD != 1 || nI != 1) begin nBad++; $display("FAIL cont_done_count: wr=%0d d=%0d i=%0d want 1 1 1", nWr, nD, nI); end
        nVec++;
        if (wrK != 1 || dK != 15 || iK != 29) begin nBad++; $display("FAIL cont_order: wr@%0d d@%0d i@%0d want 1 15 29", wrK, dK, iK); end
        nVec++;
        if (dBeats != 8 || iBeats != 8) begin nBad++; $display("FAIL cont_beats: d=%0d i=%0d want 8 8", dBeats, iBeats); end
    endtask

    task automatic test_wrap;
        logic [15:0] a;
        d_miss_addr = 16'hFFF8;
        d_miss_req  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k <= 8) begin
                a = 16'hFFF0 + 16'(2 * (k - 1));
                nVec++;
                if (mem_en !== 1'b1 || mem_addr !== a) begin nBad++; $display("FAIL wrap_addr k=%0d: en=%b addr=%h want %h", k, mem_en, mem_addr, a); end
            end
            if (k >= 5 && k <= 12) begin
                a = 16'hFFF0 + 16'(2 * (k - 5));
                nVec++;
                if (fill_valid !== 1'b1 || fill_sel !== 1'b1 || fill_word !== 3'(k - 5) || fill_data !== (a ^ 16'h5A5A)) begin
                    nBad++; $display("FAIL wrap_beat k=%0d: v=%b sel=%b word=%0d data=%h want word=%0d data=%h",
                                     k, fill_valid, fill_sel, fill_word, fill_data, k - 5, a ^ 16'h5A5A);
                end
            end
            if (k == 13) begin
                nVec++;
                if (d_fill_done !== 1'b1) begin nBad++; $display("FAIL wrap_done: d_fill_done=%b want 1", d_fill_done); end
                d_miss_req = 1'b0;
            end
        end
    endtask

    task automatic test_stall;
        int beats = 0, nDone = 0, doneK = -1;
        logic [15:0] a;
        logic expV;
        extra[3] = 2; extra[4] = 2;
        i_miss_addr = 16'h4440;
        i_miss_req  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            expV = (k >= 5 && k <= 7) || (k >= 10 && k <= 14);
            nVec++;
            if (fill_valid !== expV) begin nBad++; $display("FAIL stall_valid k=%0d: got %b want %b", k, fill_valid, expV); end
            if (fill_valid) begin
                a = 16'h4440 + 16'(2 * beats);
                nVec++;
                if (fill_word !== 3'(beats) || fill_data !== (a ^ 16'h5A5A)) begin
                    nBad++; $display("FAIL stall_beat k=%0d: word=%0d data=%h want %0d %h", k, fill_word, fill_data, beats, a ^ 16'h5A5A);
                end
                beats++;
            end
            if (i_fill_done) begin
                nDone++; doneK = k; i_miss_req = 1'b0;
                nVec++;
                if (beats != 8) begin nBad++; $display("FAIL stall_early_done: beats=%0d want 8", beats); end
            end
        end
        nVec++;
        if (nDone != 1 || doneK != 15) begin nBad++; $display("FAIL stall_done: count=%0d at k=%0d want 1 at 15", nDone, doneK); end
        extra[3] = 0; extra[4] = 0;
    endtask

    task automatic test_reset_mid;
        int beats = 0, doneK = -1;
        logic [15:0] a;
        i_miss_addr = 16'h5556;
        i_miss_req  = 1'b1;
        repeat (6) step();
        rst = 1'b1;
        i_miss_req = 1'b0;
        step();
        nVec++;
        if ({busy, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_sel, fill_word,
             fill_data, i_fill_done, d_fill_done, d_wr_done} !== '0) begin
            nBad++; $display("FAIL midrst_outputs: busy=%b en=%b addr=%h valid=%b want all 0", busy, mem_en, mem_addr, fill_valid);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            nVec++;
            if ({busy, fill_valid, i_fill_done} !== 3'b000) begin
                nBad++; $display("FAIL midrst_quiet k=%0d: busy=%b valid=%b done=%b want 000", k, busy, fill_valid, i_fill_done);
            end
        end
        i_miss_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (fill_valid) begin
                a = 16'h5550 + 16'(2 * beats);
                nVec++;
                if (fill_sel !== 1'b0 || fill_word !== 3'(beats) || fill_data !== (a ^ 16'h5A5A)) begin
                    nBad++; $display("FAIL midrst_beat k=%0d: sel=%b word=%0d data=%h want 0 %0d %h", k, fill_sel, fill_word, fill_data, beats, a ^ 16'h5A5A);
                end
                beats++;
            end
            if (i_fill_done) begin doneK = k; i_miss_req = 1'b0; end
        end
        nVec++;
        if (doneK != 13 || beats != 8) begin nBad++; $display("FAIL midrst_reissue: done at %0d beats=%0d want 13 8", doneK, beats); end
    endtask

    initial begin
        test_reset();
        test_i_miss();
        test_write();
        test_contention();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t want end before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates and sequences the single unified main memory between the I-cache miss path, the D-cache miss path and the D-side write-through path of the 16-bit CPU.
- Grants one requester at a time, with fixed priority.
- Issues a cache-line burst of pipelined reads and steers the returned words to the correct cache as indexed fill beats.
- Sits between the cache controllers and the multi-cycle memory model; the CPU stalls on the requester's pending request.

Parameters:
- LINE_WORDS, 8: 16-bit words per cache line; power of 2.
- MEM_LAT, 4: cycles from a read address being issued to its data returning with mem_data_valid.
- CNT_W, 3: width of the beat counters; equals log2(LINE_WORDS).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- i_miss_req, in, 1: I-cache line fill request; held until i_fill_done.
- i_miss_addr, in, 16: byte address of the I-side miss.
- d_miss_req, in, 1: D-cache line fill request; held until d_fill_done.
- d_miss_addr, in, 16: byte address of the D-side miss.
- d_wr_req, in, 1: single-word write-through request; held until d_wr_done.
- d_wr_addr, in, 16: write byte address.
- d_wr_data, in, 16: write data.
- mem_en, out, 1: memory access strobe.
- mem_wr, out, 1: 1 = write, 0 = read.
- mem_addr, out, 16: memory byte address.
- mem_wdata, out, 16: memory write data.
- mem_rdata, in, 16: memory read data.
- mem_data_valid, in, 1: mem_rdata is valid this cycle.
- fill_valid, out, 1: a fill beat is present this cycle.
- fill_sel, out, 1: target of the fill beat; 0 = I-cache, 1 = D-cache.
- fill_word, out, CNT_W: word index of the beat within the line.
- fill_data, out, 16: fill beat data.
- i_fill_done, out, 1: one-cycle pulse, I-side line complete.
- d_fill_done, out, 1: one-cycle pulse, D-side line complete.
- d_wr_done, out, 1: one-cycle pulse, write accepted by memory.
- busy, out, 1: 1 in any state other than IDLE.

Behaviour:
- Reset: rst is sampled on the clk rising edge. It forces state IDLE and clears both counters.
  - All outputs are 0 during and after reset until a grant.
  - Reset mid-burst abandons the burst. No done pulse is issued.
  - The memory model shares rst, so it does not return stale data after reset.
- States: IDLE, WRITE, FILL_ISSUE, FILL_DRAIN, DONE.
- IDLE:
  - Samples requests with fixed priority d_wr_req > d_miss_req > i_miss_req.
  - On a write request it goes to WRITE.
  - On a miss request it goes to FILL_ISSUE. It latches owner = D or I, and base = miss_addr with bits [log2(LINE_WORDS*2)-1:0] cleared.
  - There is no preemption: a granted transaction always completes before requests are sampled again.
- WRITE (1 cycle):
  - mem_en = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_wdata = d_wr_data.
  - d_wr_done = 1 in the same cycle.
  - Next state is IDLE.
- FILL_ISSUE (LINE_WORDS cycles):
  - mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt.
  - issue_cnt increments each cycle.
  - After the last issue (issue_cnt = LINE_WORDS-1) the next state is FILL_DRAIN.
  - Addresses wrap within 16 bits.
- FILL_ISSUE and FILL_DRAIN, return path:
  - When mem_data_valid = 1: fill_valid = 1, fill_sel = owner, fill_word = ret_cnt, fill_data = mem_rdata; ret_cnt then increments.
  - fill_valid is combinational from mem_data_valid, with no added latency.
  - When the last beat returns (ret_cnt = LINE_WORDS-1 with valid), the next state is DONE.
- DONE (1 cycle):
  - Pulses i_fill_done or d_fill_done according to owner.
  - Next state is IDLE.
  - The requester deasserts its request on that edge, so IDLE never re-grants a finished request.
- mem_data_valid is ignored in IDLE, WRITE and DONE.
- Timing with MEM_LAT = 4 and LINE_WORDS = 8, request seen in IDLE at cycle 0:
  - Reads are issued in cycles 1-8.
  - Beats arrive in cycles 5-12.
  - The done pulse is in cycle 13.
  - The next grant is possible in cycle 14.
- Simultaneous requests: the losers stay pending, with their request held, and are served in priority order on later IDLE cycles. The D-side is favoured because it stalls the older instruction.
- A request that rises while the arbiter is busy waits; its address is only captured at grant.

Test Plan:
- I miss alone: i_miss_req = 1, i_miss_addr = 0x1236.
  - Reads are issued to 0x1230, 0x1232, … 0x123E in cycles 1-8.
  - 8 beats arrive with fill_sel = 0 and fill_word = 0..7.
  - i_fill_done pulses in cycle 13.
  - busy is low in cycle 14.
- Write-through: d_wr_req = 1, addr = 0x00A4, data = 0xBEEF.
  - Cycle 1: mem_en = mem_wr = 1, mem_addr = 0x00A4, mem_wdata = 0xBEEF, d_wr_done = 1.
  - IDLE in cycle 2.
- Three-way contention: all requests rise in the same cycle.
  - Order of service is write, then D fill (fill_sel = 1), then I fill.
  - Exactly one done pulse per requester.
  - mem_en never overlaps between transactions.
- Wrap: d_miss_addr = 0xFFF8.
  - Read addresses are 0xFFF0 … 0xFFFE.
  - Beats are indexed 0-7.
- Stalled returns: the memory delays beats 3 and 4 by 2 extra cycles.
  - fill_word stays contiguous 0..7.
  - done pulses only after the 8th valid beat.
- Reset mid-burst: assert rst in cycle 6 of an I fill.
  - The next cycle shows busy = 0 and all outputs 0, with no i_fill_done.
  - A reissued request completes a full, correctly indexed line.
